// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Patterns are active-high, with bit0 = segment a and bit6 = segment g.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Glyphs: 0-9, A, b, C, d, E, F
    localparam seg7_t HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-high segment pattern.
// Output polarity is handled by the caller.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      pattern
);

    always_comb begin
        pattern = HEX_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver.
// Provides a double-buffered value, one dead cycle per digit slot, leading-zero blanking and registered outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int PRESCALE         = 50000,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  blank_all,
    output seg7_t                 segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);

    localparam logic [PW-1:0]     PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam seg7_t             SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] EN_OFF    = {DIGITS{DIGIT_ACTIVE_LOW}};

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_valid;
    logic [4*DIGITS-1:0] disp_val;
    logic [DIGITS-1:0]   disp_dp;
    logic                wrap_q;

    logic                slot_end;
    logic                wrap;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_above;
    logic [3:0]          sel_nibble;
    seg7_t               hex_pat;
    seg7_t               lit_pat;
    logic [DIGITS-1:0]   onehot;
    seg7_t               seg_nxt;
    logic                dp_nxt;
    logic [DIGITS-1:0]   en_nxt;

    assign slot_end = (pcnt == PCNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // load is a single-cycle strobe with no backpressure; a load that lands
    // on the wrap edge wins over the commit clearing pend_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else begin
            if (wrap && pend_valid) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (wrap) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Digit i (i >= 1) blanks when it and every more-significant nibble are zero.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_val[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end

    assign sel_nibble = disp_val[4*idx +: 4];

    seg7_hex_decoder u_dec (
        .nibble  (sel_nibble),
        .pattern (hex_pat)
    );

    always_comb begin
        seg_nxt = SEG_OFF;
        dp_nxt  = DP_OFF;
        en_nxt  = EN_OFF;
        onehot  = DIGITS'(1) << idx;
        lit_pat = (blank_lz && lz_mask[idx]) ? 7'h00 : hex_pat;
        if (!blank_all && (pcnt != '0)) begin
            en_nxt  = DIGIT_ACTIVE_LOW ? ~onehot : onehot;
            seg_nxt = SEG_ACTIVE_LOW ? ~lit_pat : lit_pat;
            dp_nxt  = SEG_ACTIVE_LOW ? ~disp_dp[idx] : disp_dp[idx];
        end
    end

    // frame_done is delayed one extra stage so it lines up with digit 0's dead output cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments   <= SEG_OFF;
            dp         <= DP_OFF;
            digit_en   <= EN_OFF;
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            segments   <= seg_nxt;
            dp         <= dp_nxt;
            digit_en   <= en_nxt;
            wrap_q     <= wrap;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, PRESCALE=4 and active-low outputs.
// Output cycle n (after edge n from reset release) reflects scan state n-1.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        blank_all = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [3:0] en_tbl [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .blank_all(blank_all), .segments(segments),
        .dp(dp), .digit_en(digit_en), .frame_done(frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        blank_lz = 1'b0; blank_all = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (segments !== 7'h7F) begin n_err++; $display("FAIL reset_seg got=%h exp=7f", segments); end
        n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_cmp++; if (digit_en !== 4'hF) begin n_err++; $display("FAIL reset_en got=%h exp=f", digit_en); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        apply_reset();
        tick();
        n_cmp++; if (digit_en !== 4'hF) begin n_err++; $display("FAIL first_dead_en got=%h exp=f", digit_en); end
        tick();
        n_cmp++; if (digit_en !== 4'hE) begin n_err++; $display("FAIL first_lit_en got=%h exp=e", digit_en); end
        n_cmp++; if (segments !== 7'h40) begin n_err++; $display("FAIL first_lit_seg got=%h exp=40", segments); end
        while (cyc < 6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (segments !== 7'h7F) begin n_err++; $display("FAIL midreset_seg got=%h exp=7f", segments); end
        n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL midreset_dp got=%b exp=1", dp); end
        n_cmp++; if (digit_en !== 4'hF) begin n_err++; $display("FAIL midreset_en got=%h exp=f", digit_en); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL midreset_fd got=%b exp=0", frame_done); end
    endtask

    task automatic test_scan();
        logic [6:0] seg_tbl [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        int j;
        logic dead;
        logic [6:0] exp_seg;
        logic exp_dp;
        logic exp_fd;
        apply_reset();
        value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 16) tick();
        for (int n = 17; n <= 33; n++) begin
            tick();
            j = (cyc - 1) % 16;
            dead = (j % 4 == 0);
            exp_seg = dead ? 7'h7F : seg_tbl[j / 4];
            exp_dp = (!dead && (j / 4 == 2)) ? 1'b0 : 1'b1;
            exp_fd = (cyc == 17) || (cyc == 33);
            n_cmp++; if (digit_en !== en_tbl[j]) begin n_err++; $display("FAIL scan_en cyc=%0d got=%h exp=%h", cyc, digit_en, en_tbl[j]); end
            n_cmp++; if (segments !== exp_seg) begin n_err++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, segments, exp_seg); end
            n_cmp++; if (dp !== exp_dp) begin n_err++; $display("FAIL scan_dp cyc=%0d got=%b exp=%b", cyc, dp, exp_dp); end
            n_cmp++; if (frame_done !== exp_fd) begin n_err++; $display("FAIL scan_fd cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
        end
    endtask

    task automatic test_lz();
        logic [6:0] lz_tbl [4] = '{7'h40, 7'h19, 7'h7F, 7'h7F};
        int j;
        logic [6:0] exp_seg;
        apply_reset();
        blank_lz = 1'b1; value = 16'h0040; load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 16) tick();
        for (int n = 17; n <= 32; n++) begin
            tick();
            j = (cyc - 1) % 16;
            exp_seg = (j % 4 == 0) ? 7'h7F : lz_tbl[j / 4];
            n_cmp++; if (segments !== exp_seg) begin n_err++; $display("FAIL lz_0040 cyc=%0d got=%h exp=%h", cyc, segments, exp_seg); end
        end
        apply_reset();
        blank_lz = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            j = (cyc - 1) % 16;
            exp_seg = ((j % 4 != 0) && (j / 4 == 0)) ? 7'h40 : 7'h7F;
            n_cmp++; if (segments !== exp_seg) begin n_err++; $display("FAIL lz_0000 cyc=%0d got=%h exp=%h", cyc, segments, exp_seg); end
        end
    endtask

    task automatic test_double_buffer();
        int j;
        logic [6:0] exp_seg;
        logic exp_fd;
        apply_reset();
        value = 16'h1111; load = 1'b1;
        tick();
        load = 1'b0;
        while (cyc < 16) tick();
        for (int n = 17; n <= 48; n++) begin
            tick();
            j = (cyc - 1) % 16;
            exp_seg = (j % 4 == 0) ? 7'h7F : ((cyc <= 32) ? 7'h79 : 7'h30);
            exp_fd = (cyc == 17) || (cyc == 33);
            n_cmp++; if (segments !== exp_seg) begin n_err++; $display("FAIL dbuf_seg cyc=%0d got=%h exp=%h", cyc, segments, exp_seg); end
            n_cmp++; if (frame_done !== exp_fd) begin n_err++; $display("FAIL dbuf_fd cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
            if (cyc == 20) begin value = 16'h2222; load = 1'b1; end
            else if (cyc == 22) begin value = 16'h3333; load = 1'b1; end
            else load = 1'b0;
        end
    endtask

    task automatic test_back_to_back_wrap_load();
        int j;
        logic [6:0] exp_seg;
        apply_reset();
        while (cyc < 15) tick();
        value = 16'h5555; load = 1'b1;
        tick();
        load = 1'b0;
        for (int n = 17; n <= 48; n++) begin
            tick();
            j = (cyc - 1) % 16;
            exp_seg = (j % 4 == 0) ? 7'h7F : ((cyc <= 32) ? 7'h40 : 7'h12);
            n_cmp++; if (segments !== exp_seg) begin n_err++; $display("FAIL wrapload_seg cyc=%0d got=%h exp=%h", cyc, segments, exp_seg); end
        end
    endtask

    task automatic test_blank_all();
        int j;
        logic blanked;
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        logic exp_fd;
        apply_reset();
        for (int n = 1; n <= 20; n++) begin
            tick();
            j = (cyc - 1) % 16;
            blanked = (cyc >= 6) && (cyc <= 13);
            exp_en = blanked ? 4'hF : en_tbl[j];
            exp_seg = (blanked || (j % 4 == 0)) ? 7'h7F : 7'h40;
            exp_fd = (cyc == 17);
            n_cmp++; if (digit_en !== exp_en) begin n_err++; $display("FAIL blank_en cyc=%0d got=%h exp=%h", cyc, digit_en, exp_en); end
            n_cmp++; if (segments !== exp_seg) begin n_err++; $display("FAIL blank_seg cyc=%0d got=%h exp=%h", cyc, segments, exp_seg); end
            n_cmp++; if (dp !== 1'b1) begin n_err++; $display("FAIL blank_dp cyc=%0d got=%b exp=1", cyc, dp); end
            n_cmp++; if (frame_done !== exp_fd) begin n_err++; $display("FAIL blank_fd cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
            if (cyc == 5) blank_all = 1'b1;
            if (cyc == 13) blank_all = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_double_buffer();
        test_back_to_back_wrap_load();
        test_blank_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed 7-segment display driver for DIGITS hex digits sharing one segment bus. It double-buffers a packed nibble vector, scans the digits with a programmable prescaler and inserts one dead cycle between digits against ghosting. It adds leading-zero suppression, decimal points and global blanking. It sits between datapath/status logic and the board display pins, replacing per-digit combinational decoders.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (1..8)
- PRESCALE, 50000, clocks per digit slot (≥2)
- SEG_ACTIVE_LOW, 1, segments and dp driven low = lit
- DIGIT_ACTIVE_LOW, 1, digit enables driven low = selected

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- load  in  1  capture value/dp_in into the pending buffer this cycle
- value  in  4*DIGITS  nibble i = bits [4i+3:4i]; digit 0 is least significant
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- blank_lz  in  1  enable leading-zero suppression (level, sampled live)
- blank_all  in  1  force all outputs inactive (level, sampled live)
- segments  out  7  bit0=a … bit6=g, polarity per SEG_ACTIVE_LOW
- dp  out  1  decimal point of the current digit
- digit_en  out  DIGITS  one-hot digit select, polarity per DIGIT_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse when the scan wraps DIGITS-1 → 0

## Operation
- Pending buffer: on `load`, capture value/dp_in and set `pend_valid`. A later load before commit overwrites the buffer; the last load wins.
- Commit: at the wrap edge, if `pend_valid`, copy pending → display registers and clear `pend_valid`. A load in the wrap cycle itself goes to pending and commits at the next wrap. The display never changes mid-frame.
- Prescaler `pcnt` counts 0..PRESCALE-1. At PRESCALE-1, `pcnt` → 0 and the digit index `idx` advances. At DIGITS-1, `idx` wraps to 0, frame_done pulses and the commit occurs.
- Dead cycle: while `pcnt`==0, all digit_en are inactive and segments/dp are inactive.
- Otherwise, digit_en selects `idx`, segments = hex pattern of display nibble `idx`, dp = display dp[`idx`].
- Hex patterns (active-high g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Invert when SEG_ACTIVE_LOW.
- Leading-zero suppression: when blank_lz=1, digit i blanks its segments if all display nibbles i..DIGITS-1 are zero, for i ≥ 1. Digit 0 is never suppressed. dp is unaffected.
- blank_all=1: segments, dp and digit_en are all inactive; scanning and commit continue unaffected.

## Timing
- Outputs are registered. They reflect the `pcnt`/`idx`/display state and the blank inputs of the previous cycle, so latency is 1 clock.
- Each digit is lit for PRESCALE-1 cycles per slot. Frame period is DIGITS*PRESCALE cycles.
- frame_done is registered and high in the cycle after the wrap edge, aligned with the first (dead) output cycle of digit 0.
- Reset, asynchronous and possible at any point including mid-frame: pcnt=0, idx=0, display=0, dp regs=0, pending cleared.
- Reset values of outputs: segments=all inactive (7'h7F when active-low), dp inactive, digit_en all inactive, frame_done=0.
- The first lit digit after reset release is digit 0, two cycles after release.

## Structure
- Package `seg7_pkg` holds:
  - the 16-entry hex pattern constant (active-high)
  - the segment bit-index localparams a..g
  - a `seg7_t` 7-bit typedef
- One sub-module, `seg7_hex_decoder`: combinational nibble → active-high pattern from the package table. The driver handles polarity.
- The driver contains the prescaler, the index counter, the pending/display buffers, the LZ mask logic and the output registers.

## Test plan
All cases use DIGITS=4, PRESCALE=4, both polarities active-low.
- Reset: during and after rst_n=0 → segments=7'h7F, dp=1, digit_en=4'hF, frame_done=0. Assert rst_n mid-slot → same values immediately.
- Scan: load 16'h12AF and wait one frame → digit_en cycles through F,E,E,E,F,D,D,D,F,B,B,B,F,7,7,7. Segments are 0E (F), 08 (A), 24 (2), 79 (1) on digits 0..3. frame_done pulses every 16 cycles.
- LZ: blank_lz=1 with value 16'h0040 → digits 3 and 2 show 7'h7F, digit 1 shows 19, digit 0 shows 40. With value 16'h0000 → only digit 0 lit, showing 40.
- Double buffer: display 16'h1111, then load 16'h2222 mid-frame and 16'h3333 two cycles later → digits show 79 until frame_done, then 30 (3). Never 24 (2).
- Load on the wrap edge: load 16'h5555 in the cycle `idx`/`pcnt` wrap → the current frame still shows the old value. The next frame shows 12 (5).
- blank_all=1 for 8 cycles mid-frame → segments=7F and digit_en=F during that window. frame_done timing is unchanged.
